// File: rtl/bist_ctrl.sv
// BIST controller: 3-bit LFSR drives a full-adder parity CUT whose sum is compressed into a 4-bit signature, then checked against GOLDEN_SIG.
// Optional BIST_CTRL_FAULT_INJ_EN adds a fault_inj input that inverts the CUT output during RUN.
module bist_ctrl #(
    parameter int         NUM_PATTERNS = 7,
    parameter logic [3:0] GOLDEN_SIG   = 4'h4,
    parameter logic [2:0] LFSR_SEED    = 3'b111,
    parameter logic [3:0] MISR_SEED    = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
`ifdef BIST_CTRL_FAULT_INJ_EN
    input  logic       fault_inj,
`endif
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] signature,
    output logic [2:0] pattern
);

    if (NUM_PATTERNS < 1 || NUM_PATTERNS > 255) begin : g_bad_num_patterns
        $error("bist_ctrl: NUM_PATTERNS must be in 1..255");
    end
    if (LFSR_SEED == 3'b000) begin : g_bad_lfsr_seed
        $error("bist_ctrl: LFSR_SEED must be nonzero");
    end

    typedef enum logic [1:0] {IDLE, SEED, RUN, CHECK} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       load;
    logic       adv;
    logic       check;
    logic       clr;
    logic [7:0] count;
    logic       cut_s;
    logic       sig_bit;

    localparam logic [7:0] LAST_COUNT = 8'(NUM_PATTERNS - 1);

    assign cut_s = ^pattern;
`ifdef BIST_CTRL_FAULT_INJ_EN
    assign sig_bit = cut_s ^ fault_inj;
`else
    assign sig_bit = cut_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        check     = 1'b0;
        clr       = 1'b0;
        // abort outranks everything and leaves the datapath frozen where it is
        if (abort) begin
            clr       = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        clr       = 1'b1;
                        state_nxt = SEED;
                    end
                end
                SEED: begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
                RUN: begin
                    adv = 1'b1;
                    if (count == LAST_COUNT) begin
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    check     = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern   <= LFSR_SEED;
            signature <= MISR_SEED;
            count     <= 8'd0;
        end else if (load) begin
            pattern   <= LFSR_SEED;
            signature <= MISR_SEED;
            count     <= 8'd0;
        end else if (adv) begin
            pattern   <= {pattern[1], pattern[0], pattern[1] ^ pattern[2]};
            signature <= {signature[2], signature[1], signature[0], signature[2] ^ sig_bit};
            count     <= count + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (clr) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (check) begin
            done <= 1'b1;
            pass <= (signature == GOLDEN_SIG);
        end
    end

    assign busy = (state != IDLE);

endmodule
